// File: rtl/exu_stage.sv
// Registered execute stage: ALU, branch/link resolution, EBREAK halt reporting and an
// optional shift-add multiplier, with valid/ready handshakes on both sides.
module exu_stage #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [3:0]      in_op,
   input  logic            in_src1_sel,
   input  logic            in_src2_sel,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rdata1,
   input  logic [XLEN-1:0] in_rdata2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_a0,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_brch_taken,
   output logic [XLEN-1:0] out_brch_target,
   output logic            out_halt,
   output logic [XLEN-1:0] out_halt_code
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN + 1);

   localparam logic [1:0] K_ALU = 2'd0, K_BRANCH = 2'd1, K_LINK = 2'd2, K_EBREAK = 2'd3;
   localparam logic [3:0] OP_MUL = 4'd10, OP_MULH = 4'd11, OP_MULHU = 4'd12;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [2*XLEN-1:0]   r_mcand, r_prod;
   logic [XLEN-1:0]     r_mplier;
   logic                r_neg, r_hi;

   logic                r_out_valid, r_out_taken, r_out_halt;
   logic [XLEN-1:0]     r_out_result, r_out_target, r_out_code;

   logic [XLEN-1:0]     w_src1, w_src2, w_alu, w_mag1, w_mag2, w_mul_res;
   logic [XLEN-1:0]     w_res, w_target, w_code;
   logic [SHW-1:0]      w_shamt;
   logic [2*XLEN-1:0]   w_prod_nxt, w_prod_fix;
   logic                w_br_taken, w_taken, w_halt;
   logic                w_is_mul, w_accept, w_mul_last, w_neg1, w_neg2;

   assign w_src1   = in_src1_sel ? in_pc  : in_rdata1;
   assign w_src2   = in_src2_sel ? in_imm : in_rdata2;
   assign w_shamt  = w_src2[SHW-1:0];
   assign w_is_mul = MUL_EN && (in_kind == K_ALU) &&
                     (in_op == OP_MUL || in_op == OP_MULH || in_op == OP_MULHU);
   assign w_accept   = in_valid && in_ready;
   assign w_mul_last = (r_cnt == CW'(XLEN - 1));

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      w_alu = '0;
      case (in_op)
         4'd0:    w_alu = w_src1 + w_src2;
         4'd1:    w_alu = w_src1 - w_src2;
         4'd2:    w_alu = w_src1 << w_shamt;
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src1) < $signed(w_src2))};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_src1 < w_src2)};
         4'd5:    w_alu = w_src1 ^ w_src2;
         4'd6:    w_alu = w_src1 >> w_shamt;
         4'd7:    w_alu = $signed(w_src1) >>> w_shamt;
         4'd8:    w_alu = w_src1 | w_src2;
         4'd9:    w_alu = w_src1 & w_src2;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_br_taken = 1'b0;
      case (in_op[2:0])
         3'b000:  w_br_taken = (in_rdata1 == in_rdata2);
         3'b001:  w_br_taken = (in_rdata1 != in_rdata2);
         3'b100:  w_br_taken = ($signed(in_rdata1) <  $signed(in_rdata2));
         3'b101:  w_br_taken = ($signed(in_rdata1) >= $signed(in_rdata2));
         3'b110:  w_br_taken = (in_rdata1 <  in_rdata2);
         3'b111:  w_br_taken = (in_rdata1 >= in_rdata2);
         default: w_br_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_res    = '0;
      w_taken  = 1'b0;
      w_target = '0;
      w_halt   = 1'b0;
      w_code   = '0;
      case (in_kind)
         K_ALU:    w_res = w_alu;
         K_BRANCH: begin
            w_taken  = w_br_taken;
            w_target = in_pc + in_imm;
         end
         K_LINK: begin
            w_res    = in_pc + XLEN'(4);
            w_taken  = 1'b1;
            w_target = (w_src1 + w_src2) & {{(XLEN-1){1'b1}}, 1'b0};
         end
         default: begin
            w_halt = 1'b1;
            w_code = in_a0;
         end
      endcase
   end

   // Only MULH works on signed magnitudes; MUL's low half is sign-agnostic.
   assign w_neg1     = (in_op == OP_MULH) && w_src1[XLEN-1];
   assign w_neg2     = (in_op == OP_MULH) && w_src2[XLEN-1];
   assign w_mag1     = w_neg1 ? -w_src1 : w_src1;
   assign w_mag2     = w_neg2 ? -w_src2 : w_src2;
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;
   assign w_mul_res  = r_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
         S_MUL:   if (w_mul_last)           w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_neg    <= 1'b0;
         r_hi     <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_accept && w_is_mul) begin
            r_cnt    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_prod   <= '0;
            r_neg    <= w_neg1 ^ w_neg2;
            r_hi     <= (in_op != OP_MUL);
         end
      end else begin
         r_cnt    <= r_cnt + CW'(1);
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_prod   <= w_prod_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_taken  <= 1'b0;
         r_out_target <= '0;
         r_out_halt   <= 1'b0;
         r_out_code   <= '0;
      end else if (w_accept && !w_is_mul) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_res;
         r_out_taken  <= w_taken;
         r_out_target <= w_target;
         r_out_halt   <= w_halt;
         r_out_code   <= w_code;
      end else if (r_state == S_MUL && w_mul_last) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_mul_res;
         r_out_taken  <= 1'b0;
         r_out_target <= '0;
         r_out_halt   <= 1'b0;
         r_out_code   <= '0;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid       = r_out_valid;
   assign out_result      = r_out_result;
   assign out_brch_taken  = r_out_taken;
   assign out_brch_target = r_out_target;
   assign out_halt        = r_out_halt;
   assign out_halt_code   = r_out_code;

endmodule
